// File: rtl/contador_multimodo.sv
// Multi-mode stopwatch/timer: counts prescaled ticks up to a limit or down from a preset.
// Optional CONTADOR_AUTO_RELOAD_EN: reload and keep running at the terminal value instead of stopping.
module contador_multimodo #(
    parameter int WIDTH     = 16,
    parameter int DIV_COUNT = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done
);

    localparam int PW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV_COUNT - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t           state;
    logic [PW-1:0]    prescaler;
    logic             mode_r;
    logic [WIDTH-1:0] limit_r;
    logic [WIDTH-1:0] next_count;
    logic             at_terminal;

    always_comb begin
        next_count  = mode_r ? (count - 1'b1) : (count + 1'b1);
        at_terminal = mode_r ? (next_count == '0) : (next_count == limit_r);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
            prescaler <= '0;
            mode_r    <= 1'b0;
            limit_r   <= '0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state     <= IDLE;
                count     <= '0;
                prescaler <= '0;
                running   <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            mode_r    <= mode;
                            limit_r   <= load_val;
                            prescaler <= '0;
                            count     <= mode ? load_val : '0;
                            if (load_val == '0) begin
                                // Zero-length run finishes immediately.
                                state   <= DONE;
                                done    <= 1'b1;
                                running <= 1'b0;
                            end else begin
                                state   <= RUN;
                                running <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            // Prescaler is frozen, so a tick due this cycle is deferred to resume.
                            state   <= PAUSED;
                            running <= 1'b0;
                        end else if (prescaler == PRE_LAST) begin
                            prescaler <= '0;
                            if (at_terminal) begin
                                done <= 1'b1;
`ifdef CONTADOR_AUTO_RELOAD_EN
                                count <= mode_r ? limit_r : '0;
`else
                                count   <= next_count;
                                state   <= DONE;
                                running <= 1'b0;
`endif
                            end else begin
                                count <= next_count;
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end
                    PAUSED: begin
                        if (start) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_contador_multimodo.sv
// Directed bench for contador_multimodo (WIDTH=8, DIV_COUNT=4); inputs change and outputs are sampled 1 ns after posedge.
module tb_contador_multimodo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic       clear;
    logic [7:0] count;
    logic       running;
    logic       done;

    int n_chk  = 0;
    int n_fail = 0;

    contador_multimodo #(.WIDTH(8), .DIV_COUNT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .clear    (clear),
        .count    (count),
        .running  (running),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; load_val = '0;
        start = 1'b0; pause = 1'b0; clear = 1'b0;
        step(2);
        chk("rst_count", count, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        step(2);
        chk("idle_count", count, 0);

        // Count up to 3.
        mode = 1'b0; load_val = 8'd3; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("up_accept_running", running, 1);
        chk("up_accept_count", count, 0);
        step(3);
        chk("up_c3", count, 0);
        step(1);
        chk("up_c4", count, 1);
        step(4);
        chk("up_c8", count, 2);
        step(3);
        chk("up_c11_done", done, 0);
        step(1);
`ifdef CONTADOR_AUTO_RELOAD_EN
        chk("up_c12_count", count, 0);
        chk("up_c12_done", done, 1);
        chk("up_c12_running", running, 1);
`else
        chk("up_c12_count", count, 3);
        chk("up_c12_done", done, 1);
        chk("up_c12_running", running, 0);
`endif
        step(1);
        chk("up_c13_done", done, 0);
`ifndef CONTADOR_AUTO_RELOAD_EN
        chk("up_c13_hold", count, 3);
`endif
        do_clear();

        // Count down from 2, then zero-length run.
        mode = 1'b1; load_val = 8'd2; start = 1'b1;
        step(1);
        start = 1'b0; mode = 1'b0; load_val = 8'd99;
        chk("dn_accept_count", count, 2);
        chk("dn_accept_running", running, 1);
        step(4);
        chk("dn_c4", count, 1);
        step(4);
`ifdef CONTADOR_AUTO_RELOAD_EN
        chk("dn_c8_count", count, 2);
        chk("dn_c8_done", done, 1);
        chk("dn_c8_running", running, 1);
        do_clear();
`else
        chk("dn_c8_count", count, 0);
        chk("dn_c8_done", done, 1);
        chk("dn_c8_running", running, 0);
`endif
        step(1);
        chk("dn_c9_done", done, 0);
        mode = 1'b1; load_val = 8'd0; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_count", count, 0);
        chk("zero_running", running, 0);
        step(1);
        chk("zero_done_gone", done, 0);

        // Pause on the tick-due cycle, resume later.
        mode = 1'b0; load_val = 8'd10; start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        chk("pause_count", count, 0);
        chk("pause_running", running, 0);
        step(10);
        chk("paused_hold", count, 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("resume_running", running, 1);
        chk("resume_count", count, 0);
        step(1);
        chk("resume_tick", count, 1);
        step(3);
        chk("resume_c4_pre", count, 1);
        step(1);
        chk("resume_c4", count, 2);

        // Clear beats pause and start.
        clear = 1'b1; start = 1'b1; pause = 1'b1;
        step(1);
        clear = 1'b0; start = 1'b0; pause = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_running", running, 0);
        chk("clr_done", done, 0);
        step(5);
        chk("clr_idle_hold", count, 0);

        // Async reset mid-run at count 5.
        mode = 1'b0; load_val = 8'd20; start = 1'b1;
        step(1);
        start = 1'b0;
        step(20);
        chk("pre_rst_count", count, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_running", running, 0);
        chk("arst_done", done, 0);
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("post_rst_count", count, 0);
        chk("post_rst_running", running, 0);

`ifdef CONTADOR_AUTO_RELOAD_EN
        // Periodic done with auto-reload.
        mode = 1'b0; load_val = 8'd2; start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        chk("ar_c4", count, 1);
        step(4);
        chk("ar_c8_count", count, 0);
        chk("ar_c8_done", done, 1);
        chk("ar_c8_running", running, 1);
        step(1);
        chk("ar_c9_done", done, 0);
        step(3);
        chk("ar_c12", count, 1);
        step(4);
        chk("ar_c16_done", done, 1);
        chk("ar_c16_running", running, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
